// File: rtl/mem_refill_responder_if.sv
// Refill handshake between the cache controller (master) and the refill responder (slave).
interface mem_refill_responder_if #(
  parameter int unsigned ADR_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned WORD_OFFSET = 2
);
  logic                   req_cc2mem;
  logic [ADR_WIDTH-1:0]   adr_cc2mem;
  logic                   ack_mem2cc;
  logic [DATA_WIDTH-1:0]  dat_mem2cc;
  logic [WORD_OFFSET-1:0] word_mem2cc;

  modport master (
    output req_cc2mem, adr_cc2mem,
    input  ack_mem2cc, dat_mem2cc, word_mem2cc
  );

  modport slave (
    input  req_cc2mem, adr_cc2mem,
    output ack_mem2cc, dat_mem2cc, word_mem2cc
  );
endinterface

// File: rtl/mem_refill_responder.sv
// Cache-line refill responder: fixed-latency, one beat every other cycle, from a backdoor-loaded store.
// Define MEM_REFILL_CWF_EN for critical-word-first ordering; otherwise every line starts at word 0.
module mem_refill_responder #(
  parameter int unsigned ADR_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned WORD_OFFSET = 2,
  parameter int unsigned MEM_AW      = 10,
  parameter int unsigned LATENCY     = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  mem_refill_responder_if.slave bus,
  output logic                  busy,
  input  logic                  ld_en,
  input  logic [MEM_AW-1:0]     ld_adr,
  input  logic [DATA_WIDTH-1:0] ld_dat
);

  localparam int unsigned LINE_W = MEM_AW - WORD_OFFSET;
  localparam int unsigned DEPTH  = 1 << MEM_AW;
  localparam int unsigned CNT_W  = 4;
  localparam logic [CNT_W-1:0] CNT_INIT = (LATENCY > 1) ? CNT_W'(LATENCY - 2) : '0;

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_BEAT, S_GAP, S_DONE} state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [LINE_W-1:0]      line_q, line_d;
  logic [WORD_OFFSET-1:0] word_q, word_d;
  logic [WORD_OFFSET-1:0] beat_q, beat_d;
  logic                   ack_q, ack_d;
  logic [DATA_WIDTH-1:0]  dat_q, dat_d;
  logic [WORD_OFFSET-1:0] wrd_q, wrd_d;
  logic                   busy_q, busy_d;
  logic [MEM_AW-1:0]      rd_adr;
  logic [WORD_OFFSET-1:0] start_word;
  logic                   unused_adr;

  logic [DATA_WIDTH-1:0]  mem [DEPTH];

`ifdef MEM_REFILL_CWF_EN
  assign start_word = bus.adr_cc2mem[WORD_OFFSET+1 -: WORD_OFFSET];
`else
  assign start_word = '0;
`endif

  // Upper (aliased) and byte-offset address bits are intentionally dropped.
  assign unused_adr = ^bus.adr_cc2mem;

  // Backing store: never reset, written in any state.
  always_ff @(posedge clk) begin
    if (ld_en) mem[ld_adr] <= ld_dat;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      line_q  <= '0;
      word_q  <= '0;
      beat_q  <= '0;
      ack_q   <= 1'b0;
      dat_q   <= '0;
      wrd_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      line_q  <= line_d;
      word_q  <= word_d;
      beat_q  <= beat_d;
      ack_q   <= ack_d;
      dat_q   <= dat_d;
      wrd_q   <= wrd_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    line_d  = line_q;
    word_d  = word_q;
    beat_d  = beat_q;
    ack_d   = 1'b0;
    dat_d   = '0;
    wrd_d   = '0;
    busy_d  = 1'b0;
    rd_adr  = '0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.req_cc2mem) begin
          line_d  = bus.adr_cc2mem[MEM_AW+1 -: LINE_W];
          word_d  = start_word;
          beat_d  = '0;
          cnt_d   = CNT_INIT;
          state_d = (LATENCY > 1) ? S_WAIT : S_BEAT;
        end
      end
      S_WAIT: begin
        if (!bus.req_cc2mem)  state_d = S_IDLE;
        else if (cnt_q == '0) state_d = S_BEAT;
        else                  cnt_d   = CNT_W'(cnt_q - 1'b1);
      end
      S_BEAT: begin
        if (!bus.req_cc2mem) state_d = S_IDLE;
        else if (beat_q == '1) state_d = S_DONE;
        else                  state_d = S_GAP;
      end
      S_GAP: begin
        if (!bus.req_cc2mem) state_d = S_IDLE;
        else begin
          state_d = S_BEAT;
          word_d  = WORD_OFFSET'(word_q + 1'b1);
          beat_d  = WORD_OFFSET'(beat_q + 1'b1);
        end
      end
      S_DONE: begin
        if (!bus.req_cc2mem) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Beat data is captured as the beat starts; a store write landing on that same edge is forwarded.
    rd_adr = {line_d, word_d};
    ack_d  = (state_d == S_BEAT);
    busy_d = (state_d != S_IDLE);
    if (ack_d) begin
      wrd_d = word_d;
      dat_d = (ld_en && (ld_adr == rd_adr)) ? ld_dat : mem[rd_adr];
    end
  end

  assign bus.ack_mem2cc  = ack_q;
  assign bus.dat_mem2cc  = dat_q;
  assign bus.word_mem2cc = wrd_q;
  assign busy            = busy_q;

endmodule
